// File: rtl/src_operand_stage.sv
// Source-operand stage: selects a register (with forwarding) or an extended
// immediate and presents it from a single pipeline register with stall/flush.
module src_operand_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned IMM_W   = 8,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [1:0]                  src_sel,
  input  logic [DATA_W-1:0]           reg_src,
  input  logic [ADDR_W-1:0]           reg_addr,
  input  logic [IMM_W-1:0]            imm,
  input  logic [NUM_FWD-1:0]          fwd_en,
  input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           src1,
  output logic                        fwd_hit
);

  localparam int unsigned EXT_W = DATA_W - IMM_W;
  localparam int          NF    = int'(NUM_FWD);

  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_SEXT = 2'b01;
  localparam logic [1:0] SEL_ZEXT = 2'b10;
  localparam logic [1:0] SEL_UPP  = 2'b11;

  logic [DATA_W-1:0] reg_val;
  logic              reg_fwd;
  logic [DATA_W-1:0] sel_val;
  logic              sel_hit;

  logic [DATA_W-1:0] src1_q, src1_d;
  logic              out_valid_q, out_valid_d;
  logic              fwd_hit_q, fwd_hit_d;

  // Forwarding: walk oldest to youngest so the lowest index wins; R0 never forwards.
  always_comb begin
    reg_val = reg_src;
    reg_fwd = 1'b0;
    for (int i = NF - 1; i >= 0; i--) begin
      if (fwd_en[i] && (reg_addr != '0) &&
          (fwd_addr[i*ADDR_W +: ADDR_W] == reg_addr)) begin
        reg_val = fwd_data[i*DATA_W +: DATA_W];
        reg_fwd = 1'b1;
      end
    end
  end

  // Operand mode select.
  always_comb begin
    sel_val = reg_val;
    sel_hit = 1'b0;
    case (src_sel)
      SEL_REG: begin
        sel_val = reg_val;
        sel_hit = reg_fwd;
      end
      SEL_SEXT: sel_val = {{EXT_W{imm[IMM_W-1]}}, imm};
      SEL_ZEXT: sel_val = {{EXT_W{1'b0}}, imm};
      SEL_UPP:  sel_val = {imm, {EXT_W{1'b0}}};
      default:  sel_val = reg_val;
    endcase
  end

  // Pipeline register next-state: flush dominates stall.
  always_comb begin
    src1_d      = src1_q;
    out_valid_d = out_valid_q;
    fwd_hit_d   = fwd_hit_q;
    if (flush) begin
      src1_d      = '0;
      out_valid_d = 1'b0;
      fwd_hit_d   = 1'b0;
    end else if (!stall) begin
      src1_d      = sel_val;
      out_valid_d = in_valid;
      fwd_hit_d   = sel_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src1_q      <= '0;
      out_valid_q <= 1'b0;
      fwd_hit_q   <= 1'b0;
    end else begin
      src1_q      <= src1_d;
      out_valid_q <= out_valid_d;
      fwd_hit_q   <= fwd_hit_d;
    end
  end

  assign src1      = src1_q;
  assign out_valid = out_valid_q;
  assign fwd_hit   = fwd_hit_q;

endmodule

// File: tb/tb_src_operand_stage.sv
// Bench for src_operand_stage: directed vectors push expected outputs into a
// queue; a monitor pops one entry after each clock edge and compares.
module tb_src_operand_stage;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned NUM_FWD = 2;
  localparam int unsigned ADDR_W  = 4;

  typedef struct packed {
    logic [7:0]        id;
    logic              v;
    logic [DATA_W-1:0] d;
    logic              h;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      stall = 1'b0;
  logic                      flush = 1'b0;
  logic                      in_valid = 1'b0;
  logic [1:0]                src_sel = 2'b00;
  logic [DATA_W-1:0]         reg_src = '0;
  logic [ADDR_W-1:0]         reg_addr = '0;
  logic [IMM_W-1:0]          imm = '0;
  logic [NUM_FWD-1:0]        fwd_en = '0;
  logic [NUM_FWD*ADDR_W-1:0] fwd_addr = '0;
  logic [NUM_FWD*DATA_W-1:0] fwd_data = '0;
  logic                      out_valid;
  logic [DATA_W-1:0]         src1;
  logic                      fwd_hit;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  src_operand_stage #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .src_sel(src_sel), .reg_src(reg_src), .reg_addr(reg_addr), .imm(imm),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .src1(src1), .fwd_hit(fwd_hit)
  );

  always #5 clk = ~clk;

  task automatic check_now(input string name, input logic ev,
                           input logic [DATA_W-1:0] ed, input logic eh);
    checks++;
    if (out_valid !== ev || src1 !== ed || fwd_hit !== eh) begin
      errors++;
      $display("FAIL %s: got v=%b src1=%h hit=%b, want v=%b src1=%h hit=%b",
               name, out_valid, src1, fwd_hit, ev, ed, eh);
    end
  endtask

  // Monitor: every edge that consumed a vector produces one comparison.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== e.v || src1 !== e.d || fwd_hit !== e.h) begin
        errors++;
        $display("FAIL vec%0d: got v=%b src1=%h hit=%b, want v=%b src1=%h hit=%b",
                 e.id, out_valid, src1, fwd_hit, e.v, e.d, e.h);
      end
    end
  end

  // Drive one vector on the falling edge and record its expected result.
  task automatic drive(input logic [7:0] id, input logic st, input logic fl,
                       input logic iv, input logic [1:0] sel,
                       input logic [DATA_W-1:0] rs, input logic [ADDR_W-1:0] ra,
                       input logic [IMM_W-1:0] im, input logic [NUM_FWD-1:0] fe,
                       input logic [NUM_FWD*ADDR_W-1:0] fa,
                       input logic [NUM_FWD*DATA_W-1:0] fd,
                       input logic ev, input logic [DATA_W-1:0] ed, input logic eh);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; in_valid = iv; src_sel = sel;
    reg_src = rs; reg_addr = ra; imm = im;
    fwd_en = fe; fwd_addr = fa; fwd_data = fd;
    e.id = id; e.v = ev; e.d = ed; e.h = eh;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #3;
    check_now("reset_hold", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // id  st fl iv sel   reg_src  ra    imm    fe     faddr   fdata           exp v/d/h
    drive(1,  0, 0, 1, 2'b01, 16'h0000, 4'd0, 8'h80, 2'b00, 8'h00, 32'h0,          1, 16'hFF80, 0);
    drive(2,  0, 0, 1, 2'b10, 16'h0000, 4'd0, 8'h80, 2'b00, 8'h00, 32'h0,          1, 16'h0080, 0);
    drive(3,  0, 0, 1, 2'b11, 16'h0000, 4'd0, 8'h12, 2'b00, 8'h00, 32'h0,          1, 16'h1200, 0);
    drive(4,  0, 0, 1, 2'b01, 16'h0000, 4'd0, 8'h7F, 2'b00, 8'h00, 32'h0,          1, 16'h007F, 0);
    drive(5,  0, 0, 1, 2'b00, 16'h1111, 4'd3, 8'h00, 2'b11, 8'h33, 32'hBBBB_AAAA,  1, 16'hAAAA, 1);
    drive(6,  0, 0, 1, 2'b00, 16'h1111, 4'd3, 8'h00, 2'b10, 8'h33, 32'hBBBB_AAAA,  1, 16'hBBBB, 1);
    drive(7,  0, 0, 1, 2'b00, 16'h1111, 4'd3, 8'h00, 2'b00, 8'h33, 32'hBBBB_AAAA,  1, 16'h1111, 0);
    drive(8,  0, 0, 1, 2'b00, 16'h2222, 4'd5, 8'h00, 2'b11, 8'h53, 32'hBBBB_AAAA,  1, 16'hBBBB, 1);
    drive(9,  0, 0, 1, 2'b00, 16'h0000, 4'd0, 8'h00, 2'b11, 8'h00, 32'hBBBB_AAAA,  1, 16'h0000, 0);
    drive(10, 0, 0, 1, 2'b00, 16'h5555, 4'd0, 8'h00, 2'b11, 8'h00, 32'hBBBB_AAAA,  1, 16'h5555, 0);
    drive(11, 0, 0, 1, 2'b01, 16'h1111, 4'd3, 8'h80, 2'b11, 8'h33, 32'hBBBB_AAAA,  1, 16'hFF80, 0);
    drive(12, 0, 0, 0, 2'b10, 16'h0000, 4'd0, 8'h5A, 2'b00, 8'h00, 32'h0,          0, 16'h005A, 0);
    // Capture 1234 via forwarding, then hold through three stalled cycles.
    drive(13, 0, 0, 1, 2'b00, 16'h9999, 4'd1, 8'h00, 2'b01, 8'h01, 32'h0000_1234,  1, 16'h1234, 1);
    drive(14, 1, 0, 0, 2'b11, 16'h7777, 4'd2, 8'h77, 2'b00, 8'h00, 32'h0,          1, 16'h1234, 1);
    drive(15, 1, 0, 1, 2'b01, 16'h8888, 4'd4, 8'hF0, 2'b11, 8'h44, 32'hCCCC_DDDD,  1, 16'h1234, 1);
    drive(16, 1, 0, 1, 2'b10, 16'h6666, 4'd6, 8'h3C, 2'b01, 8'h06, 32'h0000_EEEE,  1, 16'h1234, 1);
    drive(17, 1, 1, 1, 2'b10, 16'h6666, 4'd6, 8'h3C, 2'b00, 8'h00, 32'h0,          0, 16'h0000, 0);
    drive(18, 0, 0, 1, 2'b11, 16'h0000, 4'd0, 8'hAB, 2'b00, 8'h00, 32'h0,          1, 16'hAB00, 0);
    drive(19, 0, 1, 1, 2'b11, 16'h0000, 4'd0, 8'hAB, 2'b00, 8'h00, 32'h0,          0, 16'h0000, 0);
    drive(20, 0, 0, 1, 2'b10, 16'h0000, 4'd0, 8'h21, 2'b00, 8'h00, 32'h0,          1, 16'h0021, 0);
    wait_drain();

    // Async reset between edges while a valid operand is held.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_now("async_rst", 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    check_now("rst_held", 1'b0, 16'h0000, 1'b0);
    #2;
    rst = 1'b0;
    drive(21, 0, 0, 1, 2'b10, 16'h0000, 4'd0, 8'h33, 2'b00, 8'h00, 32'h0,          1, 16'h0033, 0);
    wait_drain();

    // Reset during a stall clears held state; next unstalled edge captures fresh data.
    drive(22, 0, 0, 1, 2'b00, 16'h4321, 4'd7, 8'h00, 2'b00, 8'h00, 32'h0,          1, 16'h4321, 0);
    drive(23, 1, 0, 1, 2'b11, 16'h0000, 4'd0, 8'h99, 2'b00, 8'h00, 32'h0,          1, 16'h4321, 0);
    wait_drain();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_now("rst_in_stall", 1'b0, 16'h0000, 1'b0);
    #3;
    rst = 1'b0;
    drive(24, 1, 0, 1, 2'b11, 16'h0000, 4'd0, 8'h99, 2'b00, 8'h00, 32'h0,          0, 16'h0000, 0);
    drive(25, 0, 0, 1, 2'b11, 16'h0000, 4'd0, 8'h99, 2'b00, 8'h00, 32'h0,          1, 16'h9900, 0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/src_operand_stage.md
SRC_OPERAND_STAGE -- requirements
Module: src_operand_stage

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the operand datapath width.
REQ-002 Parameter IMM_W, default 8, SHALL set the immediate field width; DATA_W > IMM_W SHALL hold.
REQ-003 Parameter NUM_FWD, default 2, SHALL set the number of forwarding channels; index 0 is the youngest stage.
REQ-004 Parameter ADDR_W, default 4, SHALL set the register-address width.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-007 stall  in  1  SHALL hold the output register when high.
REQ-008 flush  in  1  SHALL invalidate the output register when high.
REQ-009 in_valid  in  1  SHALL qualify the current operand request.
REQ-010 src_sel  in  2  SHALL select the operand mode: 00 register, 01 sign-extended immediate, 10 zero-extended immediate, 11 upper immediate.
REQ-011 reg_src  in  DATA_W  SHALL carry the register-file read data.
REQ-012 reg_addr  in  ADDR_W  SHALL carry the register-file read address.
REQ-013 imm  in  IMM_W  SHALL carry the raw immediate field.
REQ-014 fwd_en  in  NUM_FWD  SHALL flag, per channel, a pending register write.
REQ-015 fwd_addr  in  NUM_FWD*ADDR_W  SHALL carry packed destination addresses; channel i in bits [i*ADDR_W +: ADDR_W].
REQ-016 fwd_data  in  NUM_FWD*DATA_W  SHALL carry packed write data; channel i in bits [i*DATA_W +: DATA_W].
REQ-017 out_valid  out  1  SHALL flag a valid registered operand.
REQ-018 src1  out  DATA_W  SHALL be the registered selected operand.
REQ-019 fwd_hit  out  1  SHALL be registered high when the captured operand was forwarded.

Function
REQ-020 Mode 00 SHALL select the register value; mode 01 SHALL select imm sign-extended to DATA_W.
REQ-021 Mode 10 SHALL select imm zero-extended to DATA_W; mode 11 SHALL select imm in bits [DATA_W-1 -: IMM_W] with the remaining low bits zero.
REQ-022 In mode 00, the register value SHALL be fwd_data of the lowest-index channel i with fwd_en[i]=1 and fwd_addr[i]=reg_addr; otherwise reg_src.
REQ-023 Address 0 SHALL never match a forwarding channel; reg_addr=0 in mode 00 SHALL yield reg_src unmodified.
REQ-024 Forwarding SHALL NOT apply in modes 01, 10 or 11; fwd_hit SHALL capture 0 in those modes.
REQ-025 Latency SHALL be one cycle: inputs sampled at edge N appear on src1/out_valid/fwd_hit after edge N.
REQ-026 stall=1, flush=0: src1, out_valid and fwd_hit SHALL hold their values.
REQ-027 flush=1: out_valid, fwd_hit and src1 SHALL become 0 at the next edge, regardless of stall.
REQ-028 stall=0, flush=0: out_valid SHALL capture in_valid; src1 and fwd_hit SHALL capture the selected values even when in_valid=0.
REQ-029 Operand selection SHALL be combinational ahead of the register; no combinational path from inputs to outputs.

Reset
REQ-030 rst high SHALL immediately force src1=0, out_valid=0 and fwd_hit=0, independent of clk.
REQ-031 rst asserted mid-stall SHALL clear held state; after release, the first edge with stall=0 SHALL capture fresh inputs.

Verification
REQ-032 Sign/zero extension: mode 01 with imm=8'h80 -> src1=16'hFF80; mode 10 with imm=8'h80 -> 16'h0080; mode 11 with imm=8'h12 -> 16'h1200; mode 01 with imm=8'h7F -> 16'h007F.
REQ-033 Forwarding priority: mode 00, reg_addr=3, reg_src=16'h1111, both channels enabled at address 3 (ch0 data 16'hAAAA, ch1 data 16'hBBBB) -> src1=16'hAAAA and fwd_hit=1; ch0 disabled -> src1=16'hBBBB.
REQ-034 R0 guard: reg_addr=0, fwd_en=2'b11, fwd_addr both 0, reg_src=16'h0000 -> src1=16'h0000 and fwd_hit=0.
REQ-035 Stall/flush: capture 16'h1234; stall for 3 cycles with changing inputs -> src1 stays 16'h1234; then stall=1 with flush=1 -> out_valid=0 and src1=0 next cycle.
REQ-036 Async reset: assert rst between clock edges while out_valid=1 -> outputs clear before the next edge; release rst with stall=0 and in_valid=1 -> out_valid=1 one edge later.
